// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared type definitions for the RV32I pipeline. This file holds the
// pipeline register layouts that cross the EX/MEM and MEM/WB boundaries,
// the load funct3 encodings, and the memory-stage state enum.
//
// Contents:
//   ORDER_WIDTH   width of the retirement order number in mem_wb_reg_t
//   load_f3_t     funct3 encodings of the RV32I load instructions
//   mem_state_t   memory-stage access state (IDLE, WAIT)
//   ex_mem_reg_t  EX/MEM pipeline register
//   mem_wb_reg_t  MEM/WB pipeline register (also feeds RVFI)
//   is_load_f3    true when funct3 names a supported load
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int ORDER_WIDTH = 64;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        commit;
        logic        bubble;
        logic        req_dmem_resp;
        load_f3_t    funct3;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        regf_we;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
        logic [1:0]  dmem_shift_bits;
    } ex_mem_reg_t;

    typedef struct packed {
        logic                   commit;
        logic [ORDER_WIDTH-1:0] order;
        logic [31:0]            pc;
        logic [31:0]            inst;
        logic [4:0]             rd_s;
        logic [31:0]            rd_v;
        logic                   regf_we;
        logic [31:0]            dmem_addr;
        logic [3:0]             dmem_rmask;
        logic [3:0]             dmem_wmask;
        logic [31:0]            dmem_wdata;
        logic [31:0]            dmem_rdata;
    } mem_wb_reg_t;

    function automatic logic is_load_f3(load_f3_t f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data aligner. Moves the addressed byte/halfword of the
// raw memory word down to bit 0 and sign- or zero-extends it according to
// the load funct3. Unsupported funct3 values produce zero.
//
// Ports:
//   i_rdata       raw 32-bit word returned by data memory
//   i_shift_bits  byte offset of the access within the word
//   i_funct3      load type
//   o_value       aligned, extended load value
// ---------------------------------------------------------------------------
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_shift_bits,
    input  load_f3_t    i_funct3,
    output logic [31:0] o_value
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_shift_bits, 3'b000};

    always_comb begin
        o_value = '0;
        case (i_funct3)
            LB:      o_value = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LBU:     o_value = {24'h0, w_shifted[7:0]};
            LH:      o_value = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LHU:     o_value = {16'h0, w_shifted[15:0]};
            LW:      o_value = w_shifted;
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage RV32I pipeline. Issues the data-memory
// request for loads and stores, holds the pipeline in stall until the
// response pulse, extracts load data, numbers retiring instructions, and
// registers everything into the MEM/WB register.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   ex_mem      EX/MEM register contents (held by upstream while stalled)
//   dmem_addr   word-aligned data address
//   dmem_rmask  read byte mask, asserted only in the request cycle
//   dmem_wmask  write byte mask, asserted only in the request cycle
//   dmem_wdata  store data, already lane-shifted by EX
//   dmem_rdata  read data, valid with dmem_resp
//   dmem_resp   one-cycle response pulse
//   stall       freezes everything upstream of MEM/WB
//   mem_wb      registered MEM/WB contents
// ---------------------------------------------------------------------------
module mem_stage
    import rv32i_types::*;
#(
    parameter int ORDER_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_mem_reg_t ex_mem,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output mem_wb_reg_t mem_wb
);

    mem_state_t         r_state;
    mem_state_t         w_next_state;
    logic [ORDER_W-1:0] r_order;
    mem_wb_reg_t        r_mem_wb;
    mem_wb_reg_t        w_wb;
    logic               w_access;
    logic               w_rd_nonzero;
    logic               w_stall;
    logic [3:0]         w_rmask;
    logic [3:0]         w_wmask;
    logic [31:0]        w_load_value;

    // A real access needs the request flag, a live instruction and a mask.
    assign w_access     = ex_mem.req_dmem_resp & ~ex_mem.bubble
                        & (|(ex_mem.dmem_rmask | ex_mem.dmem_wmask));
    assign w_rd_nonzero = |ex_mem.rd_s;

    load_align u_load_align (
        .i_rdata      (dmem_rdata),
        .i_shift_bits (ex_mem.dmem_shift_bits),
        .i_funct3     (ex_mem.funct3),
        .o_value      (w_load_value)
    );

    // Next-state, memory-port and next-MEM/WB logic. The default MEM/WB
    // value is a bubble that still carries the EX/MEM RVFI fields, so
    // every branch only has to override what makes the cycle retire.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_rmask      = 4'h0;
        w_wmask      = 4'h0;

        w_wb            = '0;
        w_wb.order      = r_order;
        w_wb.pc         = ex_mem.pc;
        w_wb.inst       = ex_mem.inst;
        w_wb.rd_s       = ex_mem.rd_s;
        w_wb.rd_v       = ex_mem.rd_v;
        w_wb.dmem_addr  = ex_mem.dmem_addr;
        w_wb.dmem_rmask = ex_mem.dmem_rmask;
        w_wb.dmem_wmask = ex_mem.dmem_wmask;
        w_wb.dmem_wdata = ex_mem.dmem_wdata;

        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_rmask      = ex_mem.dmem_rmask;
                    w_wmask      = ex_mem.dmem_wmask;
                    w_stall      = 1'b1;
                    w_next_state = WAIT;
                end else begin
                    w_wb.commit  = ex_mem.commit & ~ex_mem.bubble;
                    w_wb.regf_we = ex_mem.regf_we & ~ex_mem.bubble & w_rd_nonzero;
                end
            end
            WAIT: begin
                if (dmem_resp) begin
                    w_next_state    = IDLE;
                    w_wb.commit     = ex_mem.commit;
                    w_wb.dmem_rdata = dmem_rdata;
                    // Stores retire without a register write.
                    if (|ex_mem.dmem_rmask) begin
                        if (is_load_f3(ex_mem.funct3)) begin
                            w_wb.rd_v    = w_load_value;
                            w_wb.regf_we = ex_mem.regf_we & w_rd_nonzero;
                        end else begin
                            w_wb.rd_v    = '0;
                        end
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // The memory port and stall stay quiet while reset is held, even if
        // upstream is still presenting an access.
        if (rst) begin
            w_stall = 1'b0;
            w_rmask = 4'h0;
            w_wmask = 4'h0;
        end
    end

    // State, commit-order counter and MEM/WB register. The counter moves
    // only on edges where a committing record is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_order  <= '0;
            r_mem_wb <= '0;
        end else begin
            r_state  <= w_next_state;
            r_mem_wb <= w_wb;
            if (w_wb.commit) begin
                r_order <= r_order + ORDER_W'(1);
            end
        end
    end

    assign dmem_addr  = {ex_mem.dmem_addr[31:2], 2'b00};
    assign dmem_wdata = ex_mem.dmem_wdata;
    assign dmem_rmask = w_rmask;
    assign dmem_wmask = w_wmask;
    assign stall      = w_stall;
    assign mem_wb     = r_mem_wb;

endmodule
